// File: rtl/basis_measure_seq_pkg.sv
// Shared types and constants for the basis-column measurement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package basis_measure_seq_pkg;

  // Sequencer states; encoding is fixed so debug taps read consistently.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    EMIT   = 3'd4,
    DONE   = 3'd5
  } bms_state_t;

  // Q1.15 maximum positive value, used as the "one" element of a basis vector.
  localparam logic [15:0] BMS_DRIVE_ONE = 16'h7FFF;

endpackage

// File: rtl/bms_chan_acc.sv
// One output channel: sample accumulator, round-half-up shift, saturation compare.
// Latency: rnd is combinational from the accumulator's next value (registered by the parent).
// Backpressure: none; samples are taken whenever accept is high. Saturation compare is built only with BMS_SAT_DETECT_EN.
module bms_chan_acc
  import basis_measure_seq_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] sample,
  input  logic             accept,
  input  logic             clear,
  output logic [ADC_W-1:0] rnd
`ifdef BMS_SAT_DETECT_EN
  ,
  output logic             sat_hit
`endif
);

  localparam int AW = ADC_W + AVG_LOG2;
  // Half an LSB of the averaged result; zero when no averaging is done.
  localparam logic [AW-1:0] HALF = AW'((1 << AVG_LOG2) >> 1);

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;

  // Next accumulator value and its rounded average. The accumulator is wide
  // enough that adding HALF cannot wrap and the shifted result fits ADC_W.
  always_comb begin
    acc_nxt = acc + (accept ? AW'(sample) : '0);
    rnd     = ADC_W'((acc_nxt + HALF) >> AVG_LOG2);
  end

  // Accumulator register; cleared whenever the parent is not sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

`ifdef BMS_SAT_DETECT_EN
  // Flag a sample sitting at either rail of the ADC range.
  always_comb begin
    sat_hit = accept && ((sample == '0) || (sample == '1));
  end
`endif

endmodule

// File: rtl/basis_measure_seq.sv
// Basis-column sequencer: applies e_k, waits for settling, averages 2^AVG_LOG2 ADC samples per channel, emits column k.
// Latency: column period SETTLE_CYC + 2^AVG_LOG2 + 2 cycles with adc_valid held high; all outputs registered.
// Backpressure: SAMPLE stalls indefinitely on missing adc_valid; col_valid/done are unacknowledged pulses. BMS_SAT_DETECT_EN enables sat.
module basis_measure_seq
  import basis_measure_seq_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ADC_W      = 12,
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 16,
  parameter int AVG_LOG2   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_CH*ADC_W-1:0]     adc_data,
  input  logic                      adc_valid,
  output logic [N_CH*DATA_W-1:0]    drive_vec,
  output logic                      drive_valid,
  output logic [N_CH*ADC_W-1:0]     col_data,
  output logic [$clog2(N_CH)-1:0]   col_idx,
  output logic                      col_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      sat
);

  localparam int CW = $clog2(N_CH);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int NS = 1 << AVG_LOG2;
  localparam logic [CW-1:0]     LAST_COL    = CW'(N_CH - 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [AVG_LOG2:0] LAST_SAMP   = (AVG_LOG2 + 1)'(NS - 1);

  bms_state_t state, next_state;
  logic [CW-1:0]          col, col_nxt;
  logic [SW-1:0]          settle_cnt;
  logic [AVG_LOG2:0]      samp_cnt;
  logic                   accept;
  logic                   acc_clear;
  logic                   drive_en;
  logic [N_CH*DATA_W-1:0] drive_nxt;
  logic [N_CH*ADC_W-1:0]  col_rnd;
`ifdef BMS_SAT_DETECT_EN
  logic [N_CH-1:0]        sat_hit;
`endif

  assign accept    = (state == SAMPLE) && adc_valid;
  assign acc_clear = abort || (state != SAMPLE);

  // Next-state and column-pointer logic; abort overrides everything.
  always_comb begin
    next_state = state;
    col_nxt    = col;
    if (abort) begin
      next_state = IDLE;
      col_nxt    = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          next_state = APPLY;
          col_nxt    = '0;
        end
        APPLY:  next_state = SETTLE;
        SETTLE: if (settle_cnt == '0) next_state = SAMPLE;
        SAMPLE: if (accept && (samp_cnt == LAST_SAMP)) next_state = EMIT;
        EMIT: begin
          if (col == LAST_COL) begin
            next_state = DONE;
          end else begin
            next_state = APPLY;
            col_nxt    = col + 1'b1;
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Basis vector for the upcoming cycle, so drive_vec can be registered.
  always_comb begin
    drive_nxt = '0;
    drive_en  = (next_state == APPLY) || (next_state == SETTLE) || (next_state == SAMPLE);
    if (drive_en) drive_nxt[col_nxt*DATA_W +: DATA_W] = DATA_W'(BMS_DRIVE_ONE);
  end

  // State, column, settle and sample counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
    end else begin
      state <= next_state;
      col   <= col_nxt;
      if (abort) begin
        settle_cnt <= '0;
      end else if (state == APPLY) begin
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (acc_clear) begin
        samp_cnt <= '0;
      end else if (accept) begin
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

  // Per-channel accumulators.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    bms_chan_acc #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .sample  (adc_data[i*ADC_W +: ADC_W]),
      .accept  (accept),
      .clear   (acc_clear),
      .rnd     (col_rnd[i*ADC_W +: ADC_W])
`ifdef BMS_SAT_DETECT_EN
      ,
      .sat_hit (sat_hit[i])
`endif
    );
  end

  // Registered outputs, decoded from the next state; column results hold until the next EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      drive_valid <= 1'b0;
      drive_vec   <= '0;
      col_valid   <= 1'b0;
      done        <= 1'b0;
      col_data    <= '0;
      col_idx     <= '0;
    end else begin
      busy        <= (next_state != IDLE);
      drive_valid <= drive_en;
      drive_vec   <= drive_nxt;
      col_valid   <= (next_state == EMIT);
      done        <= (next_state == DONE);
      if (next_state == EMIT) begin
        col_data <= col_rnd;
        col_idx  <= col;
      end
    end
  end

`ifdef BMS_SAT_DETECT_EN
  // Sticky saturation flag, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if ((state == IDLE) && start && !abort) begin
      sat <= 1'b0;
    end else if (|sat_hit) begin
      sat <= 1'b1;
    end
  end
`else
  assign sat = 1'b0;
`endif

endmodule
